// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state, framing and error-code definitions for uart_frame_ctrl
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COLLECT   = 2'd1,
    S_WAIT_TERM = 2'd2,
    S_FLUSH     = 2'd3
  } state_t;

  localparam int          FRAME_BYTES = 4;
  localparam logic [7:0]  TERM_BYTE   = 8'hFF;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_SHORT   = 2'b01;
  localparam logic [1:0]  ERR_NOTERM  = 2'b10;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - inter-byte idle gap timer, flags expiry after TIMEOUT_CYCLES idle cycles
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Expiry is seen on the cycle whose edge would complete the TIMEOUT_CYCLES-th idle cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - assembles 4-byte MSB-first UART frames terminated by 0xFF, with error and timeout detection
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_frame_valid,
  output logic [31:0]      o_frame_data,
  output logic             o_frame_err,
  output logic [1:0]       o_err_code,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_good_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  state_t           r_state;
  logic [2:0]       r_byte_cnt;
  logic [31:0]      r_payload;
  logic [31:0]      r_frame_data;
  logic             r_frame_valid;
  logic             r_frame_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_timer_en;
  logic w_expired;
  logic w_is_term;

  assign w_timer_en = (r_state == S_COLLECT) || (r_state == S_WAIT_TERM);
  assign w_is_term  = (i_rx_data == TERM_BYTE);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_rx_valid),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_payload     <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_good_cnt    <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (r_frame_valid && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + 1'b1;
      if (r_frame_err && (r_err_cnt != '1))    r_err_cnt  <= r_err_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && !w_is_term) begin
            r_payload  <= {24'h0, i_rx_data};
            r_byte_cnt <= 3'd1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (i_rx_valid) begin
            if (w_is_term) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_SHORT;
              r_state     <= S_IDLE;
            end else begin
              r_payload  <= {r_payload[23:0], i_rx_data};
              r_byte_cnt <= r_byte_cnt + 3'd1;
              if (r_byte_cnt == 3'(FRAME_BYTES - 1)) r_state <= S_WAIT_TERM;
            end
          end else if (w_expired) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= S_IDLE;
          end
        end
        S_WAIT_TERM: begin
          if (i_rx_valid) begin
            r_frame_err   <= !w_is_term;
            r_frame_valid <= w_is_term;
            if (w_is_term) begin
              r_frame_data <= r_payload;
              r_state      <= S_IDLE;
            end else begin
              r_err_code <= ERR_NOTERM;
              r_state    <= S_FLUSH;
            end
          end else if (w_expired) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_state     <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (i_rx_valid && w_is_term) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state == S_IDLE) r_byte_cnt <= (i_rx_valid && !w_is_term) ? 3'd1 : 3'd0;
    end
  end

  // Counters are bumped from the registered pulses, so they lag the pulse by one cycle.
  assign o_frame_valid = r_frame_valid;
  assign o_frame_data  = r_frame_data;
  assign o_frame_err   = r_frame_err;
  assign o_err_code    = r_err_code;
  assign o_busy        = (r_state != S_IDLE);
  assign o_good_cnt    = r_good_cnt;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - scoreboard bench for uart_frame_ctrl
module tb_uart_frame_ctrl;

  localparam int TMO   = 16;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_rx_valid = 1'b0;
  logic [7:0]       i_rx_data = 8'h00;
  logic             o_frame_valid;
  logic [31:0]      o_frame_data;
  logic             o_frame_err;
  logic [1:0]       o_err_code;
  logic             o_busy;
  logic [CNT_W-1:0] o_good_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_good = 0;
  int   exp_err  = 0;
  logic [31:0] last_good = 32'h0;

  uart_frame_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CNT_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_rx_valid    (i_rx_valid),
    .i_rx_data     (i_rx_data),
    .o_frame_valid (o_frame_valid),
    .o_frame_data  (o_frame_data),
    .o_frame_err   (o_frame_err),
    .o_err_code    (o_err_code),
    .o_busy        (o_busy),
    .o_good_cnt    (o_good_cnt),
    .o_err_cnt     (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_good = 0;
      exp_err  = 0;
    end else if (o_frame_valid || o_frame_err) begin
      exp_t e;
      chk("pulse_exclusive", 32'(o_frame_valid & o_frame_err), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, o_frame_valid, o_frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(o_frame_err), 32'(e.is_err));
        if (e.is_err) begin
          chk("err_code", 32'(o_err_code), 32'(e.code));
          exp_err = (exp_err == CMAX) ? CMAX : exp_err + 1;
        end else begin
          chk("frame_data", o_frame_data, e.data);
          exp_good = (exp_good == CMAX) ? CMAX : exp_good + 1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push_good(input logic [31:0] d);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.code = 2'b00;
    sb.push_back(e);
    last_good = d;
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.data = 32'h0; e.code = c;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] d);
    push_good(d);
    for (int i = 3; i >= 0; i--) send(d[8*i +: 8]);
    send(8'hFF);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    idle(2);
    chk({tag, "_good_cnt"}, 32'(o_good_cnt), 32'(exp_good));
    chk({tag, "_err_cnt"},  32'(o_err_cnt),  32'(exp_err));
  endtask

  initial begin
    idle(3);
    chk("rst_frame_data", o_frame_data, 32'h0);
    chk("rst_valid_err",  {30'd0, o_frame_valid, o_frame_err}, 32'd0);
    chk("rst_err_code",   32'(o_err_code), 32'd0);
    chk("rst_busy",       32'(o_busy), 32'd0);
    chk("rst_good_cnt",   32'(o_good_cnt), 32'd0);
    chk("rst_err_cnt",    32'(o_err_cnt), 32'd0);
    i_rst_n = 1'b1;
    idle(2);

    // Stray terminator in IDLE is ignored.
    send(8'hFF);
    idle(2);
    chk("ff_idle_busy", 32'(o_busy), 32'd0);

    send_frame(32'h12345678);
    drain("drain_basic");
    check_counts("basic");
    chk("basic_data", o_frame_data, 32'h12345678);

    push_err(2'b01);
    send(8'h12); send(8'h34); send(8'hFF);
    drain("drain_short");
    chk("short_data_kept", o_frame_data, 32'h12345678);
    send_frame(32'hAABBCCDD);
    drain("drain_resync");
    check_counts("resync");

    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    push_err(2'b10);
    send(8'h05); send(8'h06); send(8'hFF);
    drain("drain_noterm");
    idle(3);
    chk("noterm_data_kept", o_frame_data, 32'hAABBCCDD);
    chk("noterm_code_held", 32'(o_err_code), 32'(2'b10));
    chk("noterm_busy", 32'(o_busy), 32'd0);

    push_err(2'b11);
    send(8'h01); send(8'h02);
    idle(12);
    chk("tmo_not_early", 32'(sb.size()), 32'd1);
    chk("tmo_busy_pending", 32'(o_busy), 32'd1);
    drain("drain_timeout");
    idle(1);
    chk("tmo_busy", 32'(o_busy), 32'd0);
    check_counts("timeout");

    // Bytes landing exactly on the expiry cycle win over the timeout.
    push_good(32'h0BADCAFE);
    send(8'h0B); idle(TMO - 1);
    send(8'hAD); idle(TMO - 1);
    send(8'hCA); idle(TMO - 1);
    send(8'hFE); idle(TMO - 1);
    send(8'hFF);
    drain("drain_gap_edge");
    chk("gap_edge_data", o_frame_data, 32'h0BADCAFE);

    send(8'h11); send(8'h22); send(8'h33);
    i_rst_n = 1'b0;
    sb.delete();
    idle(2);
    chk("midrst_good_cnt", 32'(o_good_cnt), 32'd0);
    chk("midrst_data", o_frame_data, 32'h0);
    i_rst_n = 1'b1;
    idle(1);
    send_frame(32'h9ABCDEF0);
    drain("drain_after_rst");
    chk("after_rst_data", o_frame_data, 32'h9ABCDEF0);
    check_counts("after_rst");

    for (int i = 0; i < 5; i++) send_frame(32'h01020304 + 32'(i));
    drain("drain_sat");
    check_counts("sat");
    chk("sat_good_cnt_max", 32'(o_good_cnt), 32'(CMAX));
    chk("sat_last_data", o_frame_data, last_good);

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the maximum idle gap in clk cycles between bytes of one frame.
REQ-002 Parameter CNT_W, default 16, is the width of the statistics counters.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle strobe marking a received UART byte on rx_data.
REQ-006 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-007 frame_valid  output  1  one-cycle pulse marking a good frame.
REQ-008 frame_data  output  32  payload of the last good frame.
REQ-009 frame_err  output  1  one-cycle pulse marking a bad frame.
REQ-010 err_code  output  2  cause of the last error: 01 short, 10 no terminator, 11 timeout; holds until the next error.
REQ-011 busy  output  1  high while in COLLECT, WAIT_TERM or FLUSH.
REQ-012 good_cnt  output  CNT_W  count of good frames; saturates at all-ones.
REQ-013 err_cnt  output  CNT_W  count of bad frames; saturates at all-ones.

Function
REQ-014 A frame SHALL be exactly 4 payload bytes followed by terminator byte 8'hFF; 8'hFF is never a valid payload byte.
REQ-015 The first payload byte SHALL land in frame_data[31:24] and the fourth in [7:0], i.e. MSB first.
REQ-016 The FSM SHALL have states IDLE, COLLECT, WAIT_TERM and FLUSH.
REQ-017 IDLE: a non-FF byte SHALL be stored as byte 0 and move to COLLECT with byte count 1; an FF byte SHALL be ignored.
REQ-018 COLLECT: a non-FF byte SHALL be stored and the count incremented; when the count reaches 4 the FSM SHALL move to WAIT_TERM.
REQ-019 COLLECT: an FF byte SHALL raise frame_err with err_code=01 and return to IDLE, since the terminator also acts as resync.
REQ-020 WAIT_TERM: an FF byte SHALL copy the payload to frame_data, pulse frame_valid the next cycle and return to IDLE.
REQ-021 WAIT_TERM: a non-FF byte SHALL raise frame_err with err_code=10 and move to FLUSH.
REQ-022 FLUSH: non-FF bytes SHALL be discarded; an FF byte SHALL return to IDLE with no extra pulse.
REQ-023 The gap timer SHALL clear on every accepted rx_valid and count while in COLLECT or WAIT_TERM.
REQ-024 Reaching TIMEOUT_CYCLES SHALL raise frame_err with err_code=11 and return to IDLE.
REQ-025 rx_valid in the same cycle as timer expiry SHALL take priority: the byte is processed and no timeout occurs.
REQ-026 frame_valid and frame_err SHALL be registered, one cycle after the deciding byte, and never both high in one cycle.
REQ-027 frame_data SHALL change only on a good frame; a partial payload SHALL never be visible.
REQ-028 Each frame_valid pulse SHALL increment good_cnt and each frame_err pulse SHALL increment err_cnt, both saturating.
REQ-029 Back-to-back bytes on consecutive cycles SHALL be accepted with no lost byte.

Reset
REQ-030 Asserting reset (low) SHALL force state to IDLE, byte count 0, timer 0, frame_data=0, frame_valid=0, frame_err=0, err_code=00, busy=0, good_cnt=0 and err_cnt=0.
REQ-031 Reset mid-frame SHALL discard the partial payload with no pulse; the first byte after release starts a new frame.

Structure
REQ-032 Package uart_frame_pkg SHALL hold the state enumeration, FRAME_BYTES=4, TERM_BYTE=8'hFF and the err_code constants.
REQ-033 The gap timer SHALL be a sub-module, gap_timer, with ports clear, enable and expired, parameterised by TIMEOUT_CYCLES.

Verification
REQ-034 Bytes 12,34,56,78,FF -> one frame_valid, frame_data=32'h12345678, good_cnt=1.
REQ-035 Bytes 12,34,FF -> frame_err, err_code=01; then AA,BB,CC,DD,FF -> frame_data=32'hAABBCCDD.
REQ-036 Bytes 01,02,03,04,05,06,FF -> frame_err with err_code=10, then no pulse at FF; frame_data unchanged.
REQ-037 TIMEOUT_CYCLES=16, bytes 01,02 then 16 idle cycles -> frame_err, err_code=11, busy=0.
REQ-038 Reset asserted after byte 3 of a frame, then a full frame 9A,BC,DE,F0,FF -> frame_data=32'h9ABCDEF0 with no spurious pulse.
REQ-039 CNT_W=2, five good frames -> good_cnt stays at 3.
